// File: rtl/fifo64_unpack32_if.sv
// fifo64_unpack32_if: FIFO read side plus 32-bit stream side of the 64->32 drain stage.
// master = drain block: drives fifo_rdreq, dout, dout_valid, busy (and pop_cnt).
// slave  = environment: drives fifo_empty, fifo_q, dout_ready, flush (and cnt_clr).
// Optional stats ports exist only with FIFO64_UNPACK_STATS_EN defined.
interface fifo64_unpack32_if;
  logic        fifo_empty;
  logic [63:0] fifo_q;
  logic        fifo_rdreq;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        flush;
  logic        busy;
`ifdef FIFO64_UNPACK_STATS_EN
  logic        cnt_clr;
  logic [31:0] pop_cnt;
  modport master(input fifo_empty, fifo_q, dout_ready, flush, cnt_clr,
                 output fifo_rdreq, dout, dout_valid, busy, pop_cnt);
  modport slave(output fifo_empty, fifo_q, dout_ready, flush, cnt_clr,
                input fifo_rdreq, dout, dout_valid, busy, pop_cnt);
`else
  modport master(input fifo_empty, fifo_q, dout_ready, flush,
                 output fifo_rdreq, dout, dout_valid, busy);
  modport slave(output fifo_empty, fifo_q, dout_ready, flush,
                input fifo_rdreq, dout, dout_valid, busy);
`endif
endinterface

// File: rtl/fifo64_unpack32.sv
// fifo64_unpack32: drains a 64-bit FIFO into a 4-entry credit-limited buffer and emits 32-bit halves.
// Ports: clk, rst_n (async active-low), bus (fifo64_unpack32_if.master: FIFO pop side, 32-bit valid/ready
// stream, flush, busy). Optional pop counter (cnt_clr/pop_cnt) under FIFO64_UNPACK_STATS_EN.
// Parameters: RD_LAT (1..3) FIFO read latency, LSW_FIRST selects which half goes out first.
module fifo64_unpack32 #(
  parameter int RD_LAT    = 1,
  parameter bit LSW_FIRST = 1
) (
  input logic                  clk,
  input logic                  rst_n,
  fifo64_unpack32_if.master    bus
);
  logic [63:0]       mem_q [4];
  logic [63:0]       mem_d [4];
  logic [1:0]        wp_q, wp_d, rp_q, rp_d;
  logic              half_q, half_d;
  logic [2:0]        occ_q, occ_d;
  logic [1:0]        inf_q, inf_d;
  logic [RD_LAT-1:0] tag_q, tag_d, disc_q, disc_d;
  logic [2:0]        sum;
  logic              rdreq, ret, xfer, free;
  logic [63:0]       head;
  always_comb begin
    sum   = occ_q + {1'b0, inf_q};
    // rst_n gates the request so it drops asynchronously with the reset
    rdreq = rst_n && !bus.fifo_empty && !bus.flush && (sum < 3'd4);
    // a return emerging during flush is in flight and therefore dropped
    ret   = tag_q[RD_LAT-1] && !bus.flush;
    xfer  = (occ_q != 3'd0) && bus.dout_ready;
    free  = xfer && half_q;
    tag_d    = '0;
    disc_d   = '0;
    tag_d[0] = rdreq;
    for (int i = 1; i < RD_LAT; i++) begin
      tag_d[i]  = tag_q[i-1];
      disc_d[i] = disc_q[i-1];
    end
    if (bus.flush) begin
      disc_d = disc_d | tag_d;
      tag_d  = '0;
    end
    mem_d = mem_q;
    if (ret) mem_d[wp_q] = bus.fifo_q;
    wp_d   = bus.flush ? 2'd0 : wp_q + {1'b0, ret};
    rp_d   = bus.flush ? 2'd0 : rp_q + {1'b0, free};
    half_d = bus.flush ? 1'b0 : half_q ^ xfer;
    occ_d  = bus.flush ? 3'd0 : occ_q + {2'b0, ret} - {2'b0, free};
    inf_d  = bus.flush ? 2'd0 : inf_q + {1'b0, rdreq} - {1'b0, tag_q[RD_LAT-1]};
    head   = mem_q[rp_q];
    bus.fifo_rdreq = rdreq;
    bus.dout_valid = occ_q != 3'd0;
    bus.dout       = (occ_q == 3'd0) ? 32'd0 : ((half_q ^ !LSW_FIRST) ? head[63:32] : head[31:0]);
    bus.busy       = (occ_q != 3'd0) || (inf_q != 2'd0) || (|disc_q);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) mem_q[i] <= '0;
      wp_q   <= '0;
      rp_q   <= '0;
      half_q <= 1'b0;
      occ_q  <= '0;
      inf_q  <= '0;
      tag_q  <= '0;
      disc_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) mem_q[i] <= mem_d[i];
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      half_q <= half_d;
      occ_q  <= occ_d;
      inf_q  <= inf_d;
      tag_q  <= tag_d;
      disc_q <= disc_d;
    end
  end
`ifdef FIFO64_UNPACK_STATS_EN
  logic [31:0] pop_cnt_q, pop_cnt_d;
  always_comb begin
    pop_cnt_d   = bus.cnt_clr ? 32'd0 : pop_cnt_q + {31'd0, xfer};
    bus.pop_cnt = pop_cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pop_cnt_q <= '0;
    else pop_cnt_q <= pop_cnt_d;
  end
`endif
  // credits guarantee a return always finds a free slot
  a_credit: assert property (@(posedge clk) disable iff (!rst_n) sum <= 3'd4);
endmodule

// File: doc/fifo64_unpack32.md
Name: fifo64_unpack32

Overview:
- Read-side drain stage placed directly downstream of the 16x64 single-clock FIFO.
- Pops 64-bit words using the FIFO's rdreq/empty/q interface and tolerates a fixed read latency.
- Buffers the words in a 4-entry credit-limited skid store.
- Presents them as a 32-bit valid/ready stream, two halves per word, to the link-engine consumer.

Parameters:
- RD_LAT, 1, cycles from fifo_rdreq high to the corresponding fifo_q being valid; legal range 1..3.
- LSW_FIRST, 1, 1 = emit q[31:0] before q[63:32]; 0 = upper half first.

Ports:
- clk  input  1  single clock, all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_q  input  64  FIFO read data, valid RD_LAT cycles after fifo_rdreq.
- fifo_rdreq  output  1  FIFO pop request.
- dout  output  32  output half-word.
- dout_valid  output  1  dout holds valid data.
- dout_ready  input  1  consumer accepts dout this cycle.
- flush  input  1  synchronous discard of buffered and in-flight data.
- busy  output  1  buffer non-empty or reads in flight.

Behaviour:
- Reset: all internal state clears immediately on rst_n low. Outputs reset as follows: fifo_rdreq=0, dout=0, dout_valid=0, busy=0.
- Reset mid-operation: buffered and in-flight data are lost. Returns after reset deassertion are not tracked, so the FIFO must be reset together with this block.
- Counters:
  - occ (0..4): 64-bit entries held in the buffer.
  - inflight (0..3): issued reads not yet returned.
  - Both counters are registered.
- Issue rule: fifo_rdreq = !fifo_empty && !flush && (occ + inflight) < 4. Compute the sum at 3 bits.
- No same-cycle credit return: an entry freed this cycle enables issue only from the next cycle.
- Read return: an RD_LAT-deep shift register of valid tags tracks each issued read. When a tag emerges, fifo_q is written at the buffer write pointer (2-bit, wraps 3->0) and occ increments.
- Output:
  - dout is driven from the head entry, half selected by a half bit. Its first value is q[31:0] when LSW_FIRST=1, otherwise q[63:32].
  - dout_valid = (occ != 0).
  - dout_ready is ignored while dout_valid=0.
- Handshake: dout_valid && dout_ready = transfer.
  - Transfer on the first half: toggle the half bit.
  - Transfer on the second half: clear the half bit, advance the read pointer (wraps), decrement occ.
  - If a return and a free happen in the same cycle, occ is unchanged.
- dout and dout_valid hold stable while dout_valid && !dout_ready.
- Throughput: one half per cycle sustained when ready is held high and the FIFO is non-empty. No bubble between words, including across pointer wrap.
- Latency: fifo_rdreq in cycle t -> buffer write at the end of cycle t+RD_LAT -> dout_valid high in cycle t+RD_LAT+1.
- Flush: in the cycle after flush is sampled high:
  - occ=0, both pointers=0, half=0, dout_valid=0.
  - In-flight tags are converted to discard tags. Those returns are dropped, not written.
  - No rdreq is issued while flush=1.
  - A transfer in the same cycle as flush is counted by the consumer; the block discards it anyway.
- busy = (occ != 0) || (inflight != 0) || any discard tag pending.
- Invariant: occ + inflight <= 4 always, so a return never finds the buffer full. Overrun is impossible by construction. A simulation assertion checks it.

Optional Feature:
- Macro: FIFO64_UNPACK_STATS_EN.
- Defined: adds input cnt_clr (1) and output pop_cnt (32). pop_cnt counts completed 32-bit transfers.
  - It resets to 0 and wraps 0xFFFF_FFFF->0.
  - cnt_clr wins over a same-cycle transfer: the result is 0 and that transfer is not counted.
- Undefined: neither port nor the counter exist; the rest of the behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 with FIFO non-empty -> fifo_rdreq, dout_valid, busy and dout all 0 during reset, asynchronously.
- Single word: RD_LAT=1, LSW_FIRST=1, push 0x1111_2222_3333_4444 with dout_ready=1 -> rdreq at t, dout=0x3333_4444 at t+2, dout=0x1111_2222 at t+3, dout_valid low at t+4.
- Backpressure: FIFO holds 10 words, dout_ready=0 -> exactly 4 rdreq pulses then none. Release ready -> 20 halves in order with no gaps; pointer wraps cleanly.
- Flush in flight: RD_LAT=3, flush while inflight=2 and occ=1 -> dout_valid=0 next cycle. Both returning words are dropped; busy falls after the tags drain. The next pushed word 0xAAAA_BBBB_CCCC_DDDD appears as 0xCCCC_DDDD then 0xAAAA_BBBB.
- Empty source: fifo_empty held 1 for 100 cycles -> fifo_rdreq never asserted, busy=0.
- Stats (FIFO64_UNPACK_STATS_EN): drain 6 words -> pop_cnt=12. cnt_clr coincident with a transfer -> pop_cnt=0, and the next transfer gives 1.
